// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps a 3-input decoder stage through all inputs and records its f output as an 8-bit truth table
//
// Parameters:
//   SETTLE    cycles each input index is held before f is sampled (1..15)
//   EXPECTED  golden truth table, bit i = f for input i
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      scan request, honoured only when idle
//   f          function output returned from the decoder stage
//   w0,w1,w2   driven input index (w0 = MSB), registered
//   en         decoder enable, registered
//   busy       scan in progress
//   done       one-cycle pulse when table_out is complete
//   table_out  captured truth table, held until the next accepted start
//   mismatch   table_out differs from EXPECTED (only when TT_SCANNER_COMPARE_EN is defined, else 0)
// Configuration macro: TT_SCANNER_COMPARE_EN enables the golden-table comparator.
module truth_table_scanner #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'h6E
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f,
    output logic       w0,
    output logic       w1,
    output logic       w2,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       mismatch
);
    typedef enum logic [1:0] {IDLE, WAIT, CAPT, FIN} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;

    // idx is itself a register, so the w outputs are registered
    assign {w0, w1, w2} = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    idx       <= '0;
                    cnt       <= '0;
                    table_out <= '0;
                    en        <= 1'b1;
                    busy      <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: if (cnt == LAST) state <= CAPT;
                      else cnt <= cnt + 4'd1;
                CAPT: begin
                    table_out[idx] <= f;
                    if (idx == 3'd7) begin
                        // done/busy change here so they are visible exactly in the FIN cycle
                        idx   <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx   <= idx + 3'd1;
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TT_SCANNER_COMPARE_EN
    // the bit being captured for index 7 is still in flight, so splice f in directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mismatch <= 1'b0;
        else if (state == IDLE && start)
            mismatch <= 1'b0;
        else if (state == CAPT && idx == 3'd7)
            mismatch <= {f, table_out[6:0]} != EXPECTED;
    end
`else
    // constant zero; the reduction only keeps EXPECTED referenced and folds away
    assign mismatch = 1'b0 & ^EXPECTED;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: randomized self-checking bench for truth_table_scanner against a timing/table model
module tb_truth_table_scanner;
`ifdef TT_SCANNER_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0, start_v = 1'b0, f_v = 1'b0;
    int total = 0, passed = 0;

    logic start_a, start_b;
    logic w0_a, w1_a, w2_a, en_a, busy_a, done_a, mm_a;
    logic w0_b, w1_b, w2_b, en_b, busy_b, done_b, mm_b;
    logic [7:0] tbl_a, tbl_b;
    logic [14:0] obs_a, obs_b, obs;

    assign start_a = start_v & ~sel;
    assign start_b = start_v & sel;
    assign obs_a = {w0_a, w1_a, w2_a, en_a, busy_a, done_a, mm_a, tbl_a};
    assign obs_b = {w0_b, w1_b, w2_b, en_b, busy_b, done_b, mm_b, tbl_b};
    assign obs = sel ? obs_b : obs_a;

    truth_table_scanner #(.SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .f(f_v),
        .w0(w0_a), .w1(w1_a), .w2(w2_a), .en(en_a), .busy(busy_a),
        .done(done_a), .table_out(tbl_a), .mismatch(mm_a)
    );

    truth_table_scanner #(.SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .f(f_v),
        .w0(w0_b), .w1(w1_b), .w2(w2_b), .en(en_b), .busy(busy_b),
        .done(done_b), .table_out(tbl_b), .mismatch(mm_b)
    );

    always #5 clk = ~clk;

    function automatic logic mm_exp(input logic [7:0] t);
        return CMP && (t != 8'h6E);
    endfunction

    // Expected outputs after edge k of a scan (edge 0 = start accept):
    // index k/(st+1) is driven, and that many captures have completed.
    // Capture of index i uses f presented just before edge (i+1)(st+1).
    task automatic test_scan(input bit s, input int st, input logic [7:0] func,
                             input int noise, input int p1, input int p2, input string name);
        int n = 8 * (st + 1);
        logic [14:0] expv;
        logic [8:0] m;
        sel = s;
        start_v = 1'b1;
        f_v = 1'b0;
        @(posedge clk); #1;
        start_v = 1'b0;
        for (int k = 0; k <= n + 3; k++) begin
            if (k < n) begin
                m = (9'd1 << (k / (st + 1))) - 9'd1;
                expv = {3'(k / (st + 1)), 1'b1, 1'b1, 1'b0, 1'b0, func & m[7:0]};
            end else begin
                expv = {3'b000, 1'b0, 1'b0, k == n, mm_exp(func), func};
            end
            total++;
            if (obs !== expv)
                $display("FAIL %s edge %0d: got %h expected %h", name, k, obs, expv);
            else
                passed++;
            start_v = (k + 1 == p1) || (k + 1 == p2);
            if ((k + 1) % (st + 1) == 0 && k + 1 <= n)
                f_v = func[(k + 1) / (st + 1) - 1];
            else
                f_v = noise == 1 ? 1'($urandom) : noise == 2 ? k[0] : 1'b0;
            @(posedge clk); #1;
        end
        start_v = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_v = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({obs_a, obs_b} !== 30'd0)
            $display("FAIL reset_values: got %h %h expected 0000 0000", obs_a, obs_b);
        else
            passed++;
        start_v = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        sel = 1'b0;
        start_v = 1'b1;
        f_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        total++;
        if (obs_a !== 15'd0)
            $display("FAIL abort_async: got %h expected 0000", obs_a);
        else
            passed++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (obs_a !== 15'd0)
                $display("FAIL abort_hold cycle %0d: got %h expected 0000", k, obs_a);
            else
                passed++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs_a !== 15'd0)
            $display("FAIL abort_no_done: got %h expected 0000", obs_a);
        else
            passed++;
        test_scan(1'b0, 1, 8'h6E, 1, -1, -1, "after_abort");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++)
            test_scan(1'(r), r[0] ? 3 : 1, 8'($urandom), 1, -1, -1, "random");
    endtask

    initial begin
        test_reset();
        test_scan(1'b0, 1, 8'h6E, 0, -1, -1, "full_scan");
        test_scan(1'b0, 1, 8'h00, 0, -1, -1, "stuck_zero");
        test_scan(1'b1, 3, 8'hAA, 2, -1, -1, "settle3_toggle");
        test_scan(1'b0, 1, 8'h6E, 1, 3, 9, "start_ignored");
        test_random();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential test driver for the 3-input enabled decoder/function stage. Sweeps all eight input combinations onto `{w0,w1,w2}` with `en` asserted, samples the stage's `f` output after a programmable settle time, and assembles an 8-bit truth table. Sits directly upstream of the decoder stage, which it drives, and also consumes the decoder stage's output. Used for self-test and bring-up of that stage.

## Interface
- `SETTLE`, 1, cycles `{w0,w1,w2}` is held before `f` is sampled; legal range 1..15
- `EXPECTED`, 8'h6E, golden truth table, bit i = f for input i; 8'h6E = minterms 1,2,3,5,6
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — request a scan; sampled only in IDLE
- `f` in 1 — function output returned from the decoder stage
- `w0` out 1 — MSB of the driven input index; registered
- `w1` out 1 — middle bit of the driven input index; registered
- `w2` out 1 — LSB of the driven input index; registered
- `en` out 1 — decoder enable; registered
- `busy` out 1 — scan in progress
- `done` out 1 — one-cycle pulse, table valid
- `table_out` out 8 — captured truth table, bit i = f sampled at index i
- `mismatch` out 1 — table differs from `EXPECTED` (see Configuration)

## Operation
- FSM states: IDLE, WAIT, CAPT, FIN.
- IDLE, `start`=1 at an edge:
  - index←0, `table_out`←0, settle counter←0, `en`←1, `busy`←1, `mismatch`←0.
  - Go to WAIT.
- WAIT:
  - Settle counter increments each edge.
  - When the counter reaches SETTLE−1, go to CAPT.
- CAPT, one cycle:
  - `table_out[index]`←f.
  - If index==7: `en`←0, `{w0,w1,w2}`←000, go to FIN.
  - Otherwise: index←index+1, counter←0, go to WAIT.
- FIN:
  - `done`=1 and `busy`=0 for exactly this cycle.
  - Return to IDLE.
- `{w0,w1,w2}` always equals the 3-bit index; index 3'b101 means w0=1, w1=0, w2=1.
- Index is 3 bits and never wraps: the scan ends after index 7.
- `start` while busy or in FIN is ignored and not queued.
- `table_out` holds its value from FIN until the next accepted `start`.
- `f` is sampled only in CAPT; toggles on `f` during WAIT have no effect.

## Timing
- Reset values:
  - state IDLE
  - `w0`=`w1`=`w2`=0, `en`=0
  - `busy`=0, `done`=0, `mismatch`=0
  - `table_out`=8'h00
- Start-accept edge = edge 0. `en`=1, `busy`=1 and index 0 are visible after edge 0.
- Each index occupies SETTLE+1 cycles.
- Capture of index i occurs at edge (i+1)(SETTLE+1).
- `done` is high in the cycle after edge 8(SETTLE+1). With SETTLE=1 that is edge 16.
- A new `start` is accepted at the earliest at the edge ending the FIN cycle plus one, i.e. when back in IDLE.
- Reset mid-scan: all outputs return to reset values immediately and asynchronously. No `done` pulse. The partial table is discarded.

## Configuration
- Macro: `TT_SCANNER_COMPARE_EN`.
- Defined:
  - In CAPT of index 7, the final table (including the bit being captured) is compared to `EXPECTED`.
  - `mismatch` is registered, valid in the FIN cycle.
  - `mismatch` holds until the next accepted `start` or reset.
- Undefined:
  - `mismatch` is tied to 0.
  - `EXPECTED` is unused.
  - No comparator logic is present.

## Test plan
- Reset values: assert `rst_n`=0 mid-stream → all outputs at reset values, `table_out`=8'h00.
- Full scan, SETTLE=1, behavioural decoder model (f = minterms 1,2,3,5,6) → `done` one cycle after edge 16, `table_out`=8'h6E. With the macro defined, `mismatch`=0.
- `f` stuck at 0 → `table_out`=8'h00. With the macro defined, `mismatch`=1 during FIN and held afterwards.
- SETTLE=3, `f` toggling every cycle during WAIT, f=index[0] during CAPT → `table_out`=8'hAA, `done` after edge 32.
- `start` pulsed at edges 3 and 9 of a running scan → single scan only, one `done` pulse.
- `rst_n` low at edge 7, then `start` → no `done` from the aborted scan; new scan completes normally with `table_out`=8'h6E.
